// File: rtl/turf_trig_merge.sv
// Merges the soft/PPS/external trigger streams: once per sysclk_phase window it picks
// one source by fixed priority and applies holdoff and mask. Drop counter: TRIG_MERGE_DROP_COUNT_EN.
module turf_trig_merge #(
  parameter int NSRC           = 3,
  parameter int CAPTURE_OFFSET = 4,
  parameter int SRC_BITS       = 2
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rst_i,
  input  logic                 sysclk_phase_i,
  input  logic                 running_i,
  input  logic [NSRC-1:0]      src_mask_i,
  input  logic [15:0]          holdoff_i,
  input  logic [12*NSRC-1:0]   src_addr_i,
  input  logic [8*NSRC-1:0]    src_meta_i,
  input  logic [NSRC-1:0]      src_valid_i,
  output logic [11:0]          trig_addr_o,
  output logic [7:0]           trig_meta_o,
  output logic [SRC_BITS-1:0]  trig_src_o,
  output logic                 trig_valid_o,
  output logic [31:0]          trig_evnum_o,
  output logic                 busy_o,
  output logic [15:0]          drop_count_o
);

  // state | meaning
  // ARMED | hold_cnt == 0, the next capture may issue
  // HOLD  | hold_cnt > 0, captured candidates become drops
  typedef enum logic {ARMED, HOLD} hold_state_t;

  hold_state_t          state, state_nxt;
  logic [15:0]          hold_cnt, hold_nxt;
  logic [2:0]           phase_cnt;
  logic                 capture;
  logic [NSRC-1:0]      cand;
  logic [SRC_BITS-1:0]  win_idx;
  logic [11:0]          win_addr;
  logic [7:0]           win_meta;
  logic                 issue;
  logic [31:0]          evnum;
  logic                 trig_valid_q;

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i)        phase_cnt <= 3'd0;
    else if (sysclk_phase_i) phase_cnt <= 3'd1;
    else                     phase_cnt <= phase_cnt + 3'd1;
  end

  assign capture = (phase_cnt == 3'(CAPTURE_OFFSET));
  assign cand    = src_valid_i & ~src_mask_i;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_meta = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx  = SRC_BITS'(i);
        win_addr = src_addr_i[12*i +: 12];
        win_meta = src_meta_i[8*i +: 8];
      end
    end
  end

  assign issue = capture && running_i && (cand != '0) && (state == ARMED);

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      state    <= ARMED;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    hold_nxt  = hold_cnt;
    state_nxt = state;
    case (state)
      ARMED: begin
        if (running_i && issue && (holdoff_i != 16'd0)) begin
          hold_nxt  = holdoff_i;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!running_i || (hold_cnt == 16'd1)) begin
          hold_nxt  = '0;
          state_nxt = ARMED;
        end else begin
          hold_nxt  = hold_cnt - 16'd1;
        end
      end
      default: begin
        hold_nxt  = '0;
        state_nxt = ARMED;
      end
    endcase
  end

  assign busy_o = (state == HOLD);

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      trig_valid_q <= 1'b0;
      trig_addr_o  <= '0;
      trig_meta_o  <= '0;
      trig_src_o   <= '0;
      trig_evnum_o <= '0;
      evnum        <= '0;
    end else begin
      trig_valid_q <= issue;
      if (issue) begin
        trig_addr_o  <= win_addr;
        trig_meta_o  <= win_meta;
        trig_src_o   <= win_idx;
        trig_evnum_o <= evnum;
        evnum        <= evnum + 32'd1;
      end else if (!running_i) begin
        evnum        <= '0;
      end
    end
  end

  // A reset landing on the strobe cycle kills the strobe immediately.
  assign trig_valid_o = trig_valid_q & ~sysclk_rst_i;

`ifdef TRIG_MERGE_DROP_COUNT_EN
  localparam int PCW = $clog2(NSRC + 1);

  logic [PCW-1:0] cand_cnt;
  logic [PCW-1:0] drop_inc;
  logic [16:0]    drop_sum;
  logic [15:0]    drop_cnt;

  always_comb begin
    cand_cnt = '0;
    for (int i = 0; i < NSRC; i++) cand_cnt = cand_cnt + PCW'(cand[i]);
    drop_inc = '0;
    if (capture) drop_inc = issue ? (cand_cnt - PCW'(1)) : cand_cnt;
    drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
  end

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i)     drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                   drop_cnt <= drop_sum[15:0];
  end

  assign drop_count_o = drop_cnt;
`else
  assign drop_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_turf_trig_merge.sv
// Scoreboard bench for turf_trig_merge: window-level reference model feeds an expected
// trigger queue; a negedge monitor checks every strobe. Second instance checks saturation.
module tb_turf_trig_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, phase, running;
  logic [2:0]  mask, valid;
  logic [15:0] holdoff;
  logic [35:0] addr;
  logic [23:0] meta;
  logic [11:0] trig_addr;
  logic [7:0]  trig_meta;
  logic [1:0]  trig_src;
  logic        trig_valid, busy;
  logic [31:0] trig_evnum;
  logic [15:0] drop_count;

  logic        s_rst, s_phase, s_running;
  logic [2:0]  s_mask, s_valid;
  logic [15:0] s_holdoff;
  logic [35:0] s_addr;
  logic [23:0] s_meta;
  logic [11:0] s_trig_addr;
  logic [7:0]  s_trig_meta;
  logic [1:0]  s_trig_src;
  logic        s_trig_valid, s_busy;
  logic [31:0] s_trig_evnum;
  logic [15:0] s_drop_count;

  turf_trig_merge u_dut (
    .sysclk_i(clk), .sysclk_rst_i(rst), .sysclk_phase_i(phase), .running_i(running),
    .src_mask_i(mask), .holdoff_i(holdoff), .src_addr_i(addr), .src_meta_i(meta),
    .src_valid_i(valid), .trig_addr_o(trig_addr), .trig_meta_o(trig_meta),
    .trig_src_o(trig_src), .trig_valid_o(trig_valid), .trig_evnum_o(trig_evnum),
    .busy_o(busy), .drop_count_o(drop_count)
  );

  // Captures every clock with the phase pulse held high, to reach saturation quickly.
  turf_trig_merge #(.CAPTURE_OFFSET(1)) u_sat (
    .sysclk_i(clk), .sysclk_rst_i(s_rst), .sysclk_phase_i(s_phase), .running_i(s_running),
    .src_mask_i(s_mask), .holdoff_i(s_holdoff), .src_addr_i(s_addr), .src_meta_i(s_meta),
    .src_valid_i(s_valid), .trig_addr_o(s_trig_addr), .trig_meta_o(s_trig_meta),
    .trig_src_o(s_trig_src), .trig_valid_o(s_trig_valid), .trig_evnum_o(s_trig_evnum),
    .busy_o(s_busy), .drop_count_o(s_drop_count)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  meta;
    logic [1:0]  src;
    logic [31:0] evnum;
    longint      t;
  } exp_t;

  exp_t   q[$];
  int     vectors = 0;
  int     errors  = 0;
  longint cyc     = 0;

  // Reference model state, in interval numbers (cyc value after each posedge).
  longint      ti;
  longint      busy_until;
  logic [31:0] m_evnum;
  int          m_drops;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_drop(input int d);
`ifdef TRIG_MERGE_DROP_COUNT_EN
    return 16'(d);
`else
    return 16'h0000 + 16'(d & 0);
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0 && cyc > q[0].t) begin
      chk("trig_missing", 64'(0), 64'(1));
      void'(q.pop_front());
    end
    if (trig_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("trig_unexpected", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        chk("trig_time",  64'(cyc),        64'(e.t));
        chk("trig_addr",  64'(trig_addr),  64'(e.addr));
        chk("trig_meta",  64'(trig_meta),  64'(e.meta));
        chk("trig_src",   64'(trig_src),   64'(e.src));
        chk("trig_evnum", 64'(trig_evnum), 64'(e.evnum));
      end
    end
    if (s_trig_valid === 1'b1) chk("sat_trig_unexpected", 64'(1), 64'(0));
  end

  task automatic model_reset();
    ti         = -200;
    busy_until = -100;
    m_evnum    = 0;
    m_drops    = 0;
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(trig_valid), 64'(0));
    chk({tag, "_addr"},  64'(trig_addr),  64'(0));
    chk({tag, "_meta"},  64'(trig_meta),  64'(0));
    chk({tag, "_src"},   64'(trig_src),   64'(0));
    chk({tag, "_evnum"}, 64'(trig_evnum), 64'(0));
    chk({tag, "_busy"},  64'(busy),       64'(0));
    chk({tag, "_drops"}, 64'(drop_count), 64'(0));
  endtask

  // One 8-clock window; valid held in clocks 3..6, capture in clock 4, junk elsewhere.
  task automatic window(input logic [2:0] vmask, input logic run, input logic pulse,
                        input bit rst_mid, input int hold_new);
    logic [11:0] a [3];
    logic [7:0]  m [3];
    logic [2:0]  cand;
    int          win;
    for (int s = 0; s < 3; s++) begin
      a[s] = 12'($urandom());
      m[s] = 8'($urandom());
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      phase = (k == 0) && pulse;
      if (k == 0) begin
        running = run;
        if (!run) begin
          m_evnum = 0;
          if (busy_until > cyc) busy_until = cyc;
        end
      end
      if (k == 1 && !run && hold_new >= 0) holdoff = 16'(hold_new);
      if (k >= 3 && k <= 6) begin
        valid = vmask;
        for (int s = 0; s < 3; s++) begin
          addr[12*s +: 12] = a[s];
          meta[8*s +: 8]   = m[s];
        end
      end else begin
        valid = 3'($urandom());
        addr  = 36'({$urandom(), $urandom()});
        meta  = 24'($urandom());
      end
      if (k == 4) begin
        cand = vmask & ~mask;
        if (run && cand != 3'b000 && cyc > busy_until) begin
          win = cand[0] ? 0 : (cand[1] ? 1 : 2);
          q.push_back('{addr: a[win], meta: m[win], src: 2'(win), evnum: m_evnum, t: cyc + 1});
          m_evnum    = m_evnum + 1;
          ti         = cyc;
          busy_until = cyc + longint'(holdoff);
          m_drops    = m_drops + $countones(cand) - 1;
        end else begin
          m_drops    = m_drops + $countones(cand);
        end
        if (m_drops > 65535) m_drops = 65535;
      end
      if (rst_mid && k == 5) begin
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_suppresses_valid", 64'(trig_valid), 64'(0));
      end
      if (rst_mid && k == 6) begin
        rst = 1'b0;
        model_reset();
        check_zero("after_mid_reset");
      end
      chk("busy", 64'(busy), 64'((cyc > ti) && (cyc <= busy_until)));
      if (k == 5) chk("drop_count", 64'(drop_count), 64'(exp_drop(m_drops)));
    end
  endtask

  initial begin
    logic run;
    longint r;
    rst = 1'b1; phase = 1'b0; running = 1'b1; mask = 3'b000; valid = 3'b000;
    holdoff = 16'd0; addr = '0; meta = '0;
    s_rst = 1'b1; s_phase = 1'b1; s_running = 1'b0; s_mask = 3'b000; s_valid = 3'b111;
    s_holdoff = 16'd0; s_addr = '0; s_meta = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    window(3'b010, 1, 1, 0, -1);                 // single source
    window(3'b111, 1, 1, 0, -1);                 // all three: src 0 wins, 2 drops
    window(3'b111, 1, 1, 0, -1);
    window(3'b000, 0, 1, 0, 8);                  // holdoff 8: alternate windows
    for (int w = 0; w < 6; w++) window(3'b100, 1, w == 0, 0, -1);
    window(3'b000, 0, 1, 0, 7);                  // holdoff 7: every window
    for (int w = 0; w < 4; w++) window(3'b100, 1, 1, 0, -1);
    mask = 3'b001;
    window(3'b011, 1, 1, 0, -1);                 // masked source ignored
    window(3'b011, 1, 0, 0, -1);
    mask = 3'b000;
    window(3'b000, 0, 1, 0, 20);
    window(3'b100, 1, 1, 0, -1);                 // starts long holdoff
    window(3'b100, 0, 1, 0, -1);                 // running drops mid-holdoff
    window(3'b100, 1, 1, 0, -1);                 // evnum restarts at 0
    window(3'b000, 0, 1, 0, 3);
    window(3'b001, 1, 1, 1, -1);                 // reset on the strobe cycle
    window(3'b101, 1, 1, 0, -1);

    for (int w = 0; w < 48; w++) begin
      run = ($urandom_range(9) != 0);
      if ($urandom_range(3) == 0) mask = 3'($urandom());
      window(3'($urandom()), run, $urandom_range(3) != 0, 0, run ? -1 : int'($urandom_range(20)));
    end

    @(posedge clk); #1;
    phase = 1'b0; valid = 3'b000; running = 1'b1;
    s_rst = 1'b0;
    r = cyc;
    repeat (101) @(posedge clk);
    #1;
    chk("sat_count_100", 64'(s_drop_count), 64'(exp_drop(300)));
    repeat (21844 - 100) @(posedge clk);
    #1;
    chk("sat_count_21844", 64'(s_drop_count), 64'(exp_drop(65532)));
    @(posedge clk); #1;
    chk("sat_count_21845", 64'(s_drop_count), 64'(exp_drop(65535)));
    @(posedge clk); #1;
    chk("sat_count_21846", 64'(s_drop_count), 64'(exp_drop(65535)));
    repeat (200) @(posedge clk);
    #1;
    chk("sat_count_hold", 64'(s_drop_count), 64'(exp_drop(65535)));
    chk("sat_elapsed", 64'(cyc - r), 64'(101 + 21744 + 2 + 200));
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/turf_trig_merge.md
Name: turf_trig_merge

Overview:
Sysclk-domain stage directly downstream of the TURF trigger controller. It consumes the soft, PPS and external trigger streams, each a 12-bit address plus 8-bit metadata with a valid held 4 clocks inside each 8-clock sysclk_phase window. Once per window it samples the sources, picks one by fixed priority, applies the global holdoff and the source mask, and issues a single merged trigger with a running event number. Losers, masked-in sources arriving during holdoff, and triggers arriving while not running are counted as drops.

Parameters:
NSRC, 3, number of trigger sources; index 0 has highest priority.
CAPTURE_OFFSET, 4, clocks after the sysclk_phase_i pulse at which src_valid_i is sampled; legal range 1..7.
SRC_BITS, 2, width of trig_src_o; must satisfy 2**SRC_BITS >= NSRC.

Ports:
sysclk_i  in  1  system clock; the only clock.
sysclk_rst_i  in  1  synchronous, active-high reset.
sysclk_phase_i  in  1  one-clock pulse every 8 sysclk.
running_i  in  1  triggers may issue only while high.
src_mask_i  in  NSRC  1 = source masked, ignored completely, not counted.
holdoff_i  in  16  post-issue dead time in sysclk cycles; static while running.
src_addr_i  in  12*NSRC  per-source trigger address; source n at [12n +: 12].
src_meta_i  in  8*NSRC  per-source metadata; source n at [8n +: 8].
src_valid_i  in  NSRC  per-source valid, window-aligned.
trig_addr_o  out  12  address of the last issued trigger.
trig_meta_o  out  8  metadata of the last issued trigger.
trig_src_o  out  SRC_BITS  index of the winning source.
trig_valid_o  out  1  one-clock issue strobe.
trig_evnum_o  out  32  event number of the last issued trigger.
busy_o  out  1  holdoff counter nonzero.
drop_count_o  out  16  saturating drop counter.

Behaviour:
- Phase counter, 3 bits. On a sysclk_phase_i cycle it loads 1; otherwise it increments mod 8. The capture cycle is phase_cnt == CAPTURE_OFFSET. If the phase pulse is absent, the counter free-runs, so capture continues every 8 clocks.
- Capture cycle:
  - Candidate set cand = src_valid_i & ~src_mask_i.
  - The winner is the lowest set index.
  - Issue condition: running_i && cand != 0 && hold_cnt == 0.
- Issue, registered:
  - On the next clock trig_valid_o = 1 for exactly one cycle.
  - trig_addr_o, trig_meta_o and trig_src_o are loaded from the winner and held until the next issue.
  - trig_evnum_o is loaded with evnum, then evnum increments. The first event after running rises is 0.
- Holdoff FSM, states ARMED (hold_cnt == 0) and HOLD (hold_cnt > 0):
  - On the issue edge, hold_cnt <= holdoff_i.
  - Otherwise hold_cnt decrements, saturating at 0.
  - With holdoff_i = 0 the FSM stays in ARMED.
  - Consequence: the next window can issue iff holdoff_i <= 7.
- Drops, evaluated at the capture cycle only. The drop increment is:
  - issue: popcount(cand) - 1 (the losers);
  - no issue, because hold_cnt != 0 or running_i is low: popcount(cand).
- drop_count_o saturates at 16'hFFFF. It clears only on sysclk_rst_i.
- running_i low:
  - no issue;
  - hold_cnt <= 0;
  - evnum <= 0;
  - trig_evnum_o, trig_addr_o, trig_meta_o and trig_src_o keep their last values.
- Reset: every output is 0, hold_cnt = 0, evnum = 0, phase_cnt = 0.
  - A reset asserted in the cycle after capture suppresses trig_valid_o.
  - Reset takes priority over all other updates.
- Inputs sampled outside the capture cycle are ignored. A valid held 4 clocks yields at most one issue or drop per window.
- evnum wraps from 32'hFFFFFFFF to 0.

Optional Feature:
Macro TRIG_MERGE_DROP_COUNT_EN.
- Defined: drop counter present as described above.
- Undefined: counter logic removed and drop_count_o tied to 16'h0000. All other behaviour is unchanged.

Test Plan:
1. Reset, running=1, mask=0, holdoff=0; source 1 valid in clocks 3-6 after phase with addr 12'h123, meta 8'h80 -> one trig_valid_o pulse 5 clocks after phase with addr 12'h123, meta 8'h80, src 1, evnum 0; drop_count 0.
2. Sources 0, 1 and 2 all valid in the same window -> src 0 issued, drop_count increments by 2; next such window gives evnum 1 and drop_count 4.
3. holdoff=8, source 2 valid every window -> issues in alternate windows (evnum 0, 1, ...), one drop per blocked window. Repeat with holdoff=7 -> issues every window, no drops.
4. mask=3'b001, sources 0 and 1 valid -> src 1 issued, drop_count unchanged.
5. running deasserted mid-holdoff with a source valid -> no issue, drop_count +1, busy_o falls next clock. running reasserted -> next issue has evnum 0 and issues regardless of the prior holdoff.
6. Drive 65540 blocked triggers with the macro defined -> drop_count_o stays at 16'hFFFF. With the macro undefined -> drop_count_o stays at 0.
